// File: rtl/inst_queue.sv
// Fetch-to-decode instruction queue: circular buffer of (pc, inst, excp) entries
// with a combinational head read and pre-split opcode fields for the decoders.
module inst_queue #(
   parameter int DEPTH  = 4,
   parameter int EXCP_W = 8,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              flush,
   input  logic              fs_valid,
   output logic              fs_ready,
   input  logic [31:0]       fs_pc,
   input  logic [31:0]       fs_inst,
   input  logic [EXCP_W-1:0] fs_excp,
   output logic              ds_valid,
   input  logic              ds_ready,
   output logic [31:0]       ds_pc,
   output logic [31:0]       ds_inst,
   output logic [EXCP_W-1:0] ds_excp,
   output logic [5:0]        op_31_26,
   output logic [3:0]        op_25_22,
   output logic [1:0]        op_21_20,
   output logic [4:0]        op_19_15,
   output logic [CW-1:0]     count
);

   localparam logic [31:0] NOP_INST = 32'h0340_0000;

   typedef struct packed {
      logic [31:0]       pc;
      logic [31:0]       inst;
      logic [EXCP_W-1:0] excp;
   } entry_t;

   entry_t          mem_q [DEPTH];
   logic [AW-1:0]   rptr_q, rptr_d;
   logic [AW-1:0]   wptr_q, wptr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            push, pop;
   entry_t          head;

   // Full/empty come only from the counter; pointer equality is ambiguous.
   assign fs_ready = (cnt_q != CW'(DEPTH)) & ~flush & resetn;
   assign ds_valid = (cnt_q != '0) & ~flush;
   assign push     = fs_valid & fs_ready;
   assign pop      = ds_valid & ds_ready;
   assign count    = cnt_q;

   assign head     = mem_q[rptr_q];
   assign ds_pc    = ds_valid ? head.pc   : 32'h0;
   assign ds_inst  = ds_valid ? head.inst : NOP_INST;
   assign ds_excp  = ds_valid ? head.excp : '0;

   assign op_31_26 = ds_inst[31:26];
   assign op_25_22 = ds_inst[25:22];
   assign op_21_20 = ds_inst[21:20];
   assign op_19_15 = ds_inst[19:15];

   always_comb begin
      rptr_d = rptr_q;
      wptr_d = wptr_q;
      cnt_d  = cnt_q;
      if (flush) begin
         rptr_d = '0;
         wptr_d = '0;
         cnt_d  = '0;
      end else begin
         if (push) wptr_d = wptr_q + AW'(1);
         if (pop)  rptr_d = rptr_q + AW'(1);
         cnt_d = cnt_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rptr_q <= '0;
         wptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         rptr_q <= rptr_d;
         wptr_q <= wptr_d;
         cnt_q  <= cnt_d;
      end
   end

   // Storage carries no reset; validity is tracked entirely by cnt_q.
   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= '{pc: fs_pc, inst: fs_inst, excp: fs_excp};
   end

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue: hand-computed vectors checked with immediate assertions.
module tb_inst_queue;

   localparam int DEPTH  = 4;
   localparam int EXCP_W = 8;

   logic              clk = 1'b0;
   logic              resetn;
   logic              flush;
   logic              fs_valid;
   logic              fs_ready;
   logic [31:0]       fs_pc;
   logic [31:0]       fs_inst;
   logic [EXCP_W-1:0] fs_excp;
   logic              ds_valid;
   logic              ds_ready;
   logic [31:0]       ds_pc;
   logic [31:0]       ds_inst;
   logic [EXCP_W-1:0] ds_excp;
   logic [5:0]        op_31_26;
   logic [3:0]        op_25_22;
   logic [1:0]        op_21_20;
   logic [4:0]        op_19_15;
   logic [2:0]        count;

   int nvec = 0;
   int nerr = 0;

   inst_queue #(.DEPTH(DEPTH), .EXCP_W(EXCP_W)) dut (
      .clk(clk), .resetn(resetn), .flush(flush),
      .fs_valid(fs_valid), .fs_ready(fs_ready),
      .fs_pc(fs_pc), .fs_inst(fs_inst), .fs_excp(fs_excp),
      .ds_valid(ds_valid), .ds_ready(ds_ready),
      .ds_pc(ds_pc), .ds_inst(ds_inst), .ds_excp(ds_excp),
      .op_31_26(op_31_26), .op_25_22(op_25_22),
      .op_21_20(op_21_20), .op_19_15(op_19_15),
      .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock; checks head stability across a stalled edge and the occupancy bound.
   task automatic step();
      logic        stall;
      logic [31:0] pc, inst;
      logic [EXCP_W-1:0] ex;
      stall = ds_valid & ~ds_ready & ~flush & resetn;
      pc = ds_pc; inst = ds_inst; ex = ds_excp;
      @(posedge clk);
      #1;
      if (stall && resetn) begin
         chk("stable_pc",   ds_pc,   pc);
         chk("stable_inst", ds_inst, inst);
         chk("stable_op",   op_31_26, inst[31:26]);
         chk("stable_excp", ds_excp, ex);
      end
      chk("cnt_range", (count <= 3'(DEPTH)), 1);
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                        input logic [EXCP_W-1:0] ex);
      fs_valid = v; fs_pc = pc; fs_inst = inst; fs_excp = ex;
   endtask

   initial begin
      resetn = 1'b0; flush = 1'b0; ds_ready = 1'b0;
      drive(1'b0, 32'h0, 32'h0, '0);
      #1;
      chk("rst_ds_valid", ds_valid, 0);
      chk("rst_fs_ready", fs_ready, 0);
      chk("rst_count",    count,    0);
      chk("rst_nop",      ds_inst,  32'h0340_0000);
      step(); step();
      resetn = 1'b1;
      #1;
      chk("post_rst_fs_ready", fs_ready, 1);

      // Basic flow
      drive(1'b1, 32'h1c00_0000, 32'h0280_0c21, 8'h00);
      #1;
      chk("no_bypass", ds_valid, 0);
      step();
      drive(1'b0, 32'h0, 32'h0, '0);
      chk("basic_valid", ds_valid, 1);
      chk("basic_pc",    ds_pc, 32'h1c00_0000);
      chk("basic_op31",  op_31_26, 6'h00);
      chk("basic_op25",  op_25_22, 4'hA);
      chk("basic_op21",  op_21_20, 2'h0);
      chk("basic_op19",  op_19_15, 5'h00);
      chk("basic_count", count, 1);
      step();
      chk("basic_hold_count", count, 1);
      ds_ready = 1'b1;
      step();
      ds_ready = 1'b0;
      chk("basic_pop_count", count, 0);
      chk("basic_pop_valid", ds_valid, 0);

      // Fill to full
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'h100 + 32'(4*i), 32'h1000_0000 + 32'(i), 8'(i));
         step();
      end
      drive(1'b0, 32'h0, 32'h0, '0);
      #1;
      chk("full_fs_ready", fs_ready, 0);
      chk("full_count",    count, 4);

      // Full with simultaneous pop: push refused
      drive(1'b1, 32'hdead_0000, 32'hdead_beef, 8'hff);
      ds_ready = 1'b1;
      #1;
      chk("fullpop_fs_ready", fs_ready, 0);
      chk("fullpop_head0",    ds_pc, 32'h100);
      step();
      drive(1'b0, 32'h0, 32'h0, '0);
      chk("fullpop_count", count, 3);
      chk("fullpop_ready", fs_ready, 1);
      for (int i = 1; i < 4; i++) begin
         chk("drain_pc",   ds_pc,   32'h100 + 32'(4*i));
         chk("drain_inst", ds_inst, 32'h1000_0000 + 32'(i));
         chk("drain_excp", ds_excp, 8'(i));
         step();
      end
      chk("drain_empty", count, 0);
      chk("drain_valid", ds_valid, 0);

      // Three more pushes wrap the write pointer
      ds_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h200 + 32'(4*i), 32'h2000_0000 + 32'(i), 8'h10 + 8'(i));
         step();
      end
      drive(1'b0, 32'h0, 32'h0, '0);
      chk("wrap_count", count, 3);
      ds_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("wrap_pc",   ds_pc,   32'h200 + 32'(4*i));
         chk("wrap_inst", ds_inst, 32'h2000_0000 + 32'(i));
         chk("wrap_excp", ds_excp, 8'h10 + 8'(i));
         step();
      end
      chk("wrap_empty", count, 0);

      // Steady stream, one entry in flight, no bubbles
      drive(1'b1, 32'h2000, 32'h0280_0000, 8'h00);
      step();
      chk("stream_fill_count", count, 1);
      for (int i = 1; i < 20; i++) begin
         drive(1'b1, 32'h2000 + 32'(4*i), 32'h0280_0000 + 32'(i), 8'h00);
         chk("stream_pc",    ds_pc, 32'h2000 + 32'(4*(i-1)));
         chk("stream_count", count, 1);
         step();
      end
      drive(1'b0, 32'h0, 32'h0, '0);
      chk("stream_last_pc", ds_pc, 32'h2000 + 32'(4*19));
      step();
      chk("stream_empty", count, 0);

      // Flush beats simultaneous push and pop
      ds_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h400 + 32'(4*i), 32'h4000_0000 + 32'(i), 8'h00);
         step();
      end
      chk("flush_pre_count", count, 3);
      flush = 1'b1; ds_ready = 1'b1;
      drive(1'b1, 32'h500, 32'h5000_0000, 8'h00);
      #1;
      chk("flush_ds_valid", ds_valid, 0);
      chk("flush_fs_ready", fs_ready, 0);
      chk("flush_nop",      ds_inst, 32'h0340_0000);
      step();
      flush = 1'b0; ds_ready = 1'b0;
      drive(1'b0, 32'h0, 32'h0, '0);
      #1;
      chk("flush_count", count, 0);
      chk("flush_inst",  ds_inst, 32'h0340_0000);
      chk("flush_pc",    ds_pc, 32'h0);
      chk("flush_op31",  op_31_26, 6'h00);
      chk("flush_op25",  op_25_22, 4'hD);
      chk("flush_op21",  op_21_20, 2'h0);

      // Asynchronous reset between edges
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 32'h600 + 32'(4*i), 32'h6000_0000 + 32'(i), 8'h00);
         step();
      end
      drive(1'b0, 32'h0, 32'h0, '0);
      chk("arst_pre_count", count, 2);
      #2;
      resetn = 1'b0;
      #1;
      chk("arst_ds_valid", ds_valid, 0);
      chk("arst_count",    count, 0);
      chk("arst_fs_ready", fs_ready, 0);
      step();
      resetn = 1'b1;
      drive(1'b1, 32'h3000, 32'h1234_5678, 8'hA5);
      step();
      drive(1'b0, 32'h0, 32'h0, '0);
      chk("arst_rb_count", count, 1);
      chk("arst_rb_pc",    ds_pc, 32'h3000);
      chk("arst_rb_inst",  ds_inst, 32'h1234_5678);
      chk("arst_rb_excp",  ds_excp, 8'hA5);
      chk("arst_rb_op31",  op_31_26, 6'h04);
      chk("arst_rb_op25",  op_25_22, 4'h8);
      chk("arst_rb_op21",  op_21_20, 2'h3);
      chk("arst_rb_op19",  op_19_15, 5'h08);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
